// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operand handshake in, result handshake out.
interface alu_seq_if #(parameter int W = 8);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   s;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         z;
    logic         n;
    logic         c;
    logic         v;

    modport master (
        output in_valid, a, b, s, out_ready,
        input  in_ready, out_valid, out, z, n, c, v
    );

    modport slave (
        input  in_valid, a, b, s, out_ready,
        output in_ready, out_valid, out, z, n, c, v
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic ops, bit-serial shifts, registered result + flags.
// Optional macro ALU_SEQ_SAT_EN: saturate ADD/SUB on signed overflow instead of wrapping.
module alu_seq #(
    parameter int W   = 8,
    parameter int SHW = $clog2(W)
) (
    input  logic   clk,
    input  logic   rst_n,
    alu_seq_if.slave bus
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t         state, state_nxt;
    logic [2:0]     op_q;
    logic [W-1:0]   sh_q;
    logic [SHW-1:0] cnt_q;
    logic [W-1:0]   out_q;
    logic           z_q, n_q, c_q, v_q;

    logic           accept;
    logic           is_shift;
    logic           go_shift;
    logic [SHW-1:0] k;
    logic [W:0]     sum, diff;
    logic [W-1:0]   res;
    logic           res_c, res_v;
    logic [W-1:0]   sh_nxt;
    logic           sh_bit;
    logic           last_shift;

    assign accept     = bus.in_valid && (state == IDLE);
    assign is_shift   = (bus.s[2:1] == 2'b11);
    assign k          = bus.b[SHW-1:0];
    assign go_shift   = is_shift && (k != '0);
    assign last_shift = (cnt_q == SHW'(1));

    // op_q[0] distinguishes SHR (1) from SHL (0)
    assign sh_nxt = op_q[0] ? (sh_q >> 1) : (sh_q << 1);
    assign sh_bit = op_q[0] ? sh_q[0] : sh_q[W-1];

    always_comb begin
        sum   = {1'b0, bus.a} + {1'b0, bus.b};
        diff  = {1'b0, bus.a} - {1'b0, bus.b};
        res   = bus.a;
        res_c = 1'b0;
        res_v = 1'b0;
        case (bus.s)
            OP_ADD: begin
                res   = sum[W-1:0];
                res_c = sum[W];
                res_v = (bus.a[W-1] == bus.b[W-1]) && (sum[W-1] != bus.a[W-1]);
            end
            OP_SUB: begin
                res   = diff[W-1:0];
                res_c = diff[W];
                res_v = (bus.a[W-1] != bus.b[W-1]) && (diff[W-1] != bus.a[W-1]);
            end
            OP_AND:  res = bus.a & bus.b;
            OP_OR:   res = bus.a | bus.b;
            OP_XOR:  res = bus.a ^ bus.b;
            OP_NOT:  res = ~bus.a;
            default: res = bus.a;   // zero-length shift passes a through
        endcase
`ifdef ALU_SEQ_SAT_EN
        // Overflow flips the sign bit, so a wrapped negative means the true result was positive.
        if (res_v)
            res = res[W-1] ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = go_shift ? SHIFT : DONE;
            SHIFT:   if (last_shift)   state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            sh_q  <= '0;
            cnt_q <= '0;
            out_q <= '0;
            z_q   <= 1'b0;
            n_q   <= 1'b0;
            c_q   <= 1'b0;
            v_q   <= 1'b0;
        end else if (accept) begin
            op_q  <= bus.s;
            sh_q  <= bus.a;
            cnt_q <= k;
            if (!go_shift) begin
                out_q <= res;
                z_q   <= (res == '0);
                n_q   <= res[W-1];
                c_q   <= res_c;
                v_q   <= res_v;
            end
        end else if (state == SHIFT) begin
            sh_q  <= sh_nxt;
            cnt_q <= cnt_q - SHW'(1);
            if (last_shift) begin
                out_q <= sh_nxt;
                z_q   <= (sh_nxt == '0);
                n_q   <= sh_nxt[W-1];
                c_q   <= sh_bit;
                v_q   <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out       = out_q;
    assign bus.z         = z_q;
    assign bus.n         = n_q;
    assign bus.c         = c_q;
    assign bus.v         = v_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq at W=8 and W=16, plus backpressure and reset corner cases.
module tb_alu_seq;
    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
    localparam logic [2:0] XOR_ = 3'b100, NOT_ = 3'b101, SHL = 3'b110, SHR = 3'b111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_seq_if #(.W(8))  b8 ();
    alu_seq_if #(.W(16)) b16 ();

    alu_seq #(.W(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
    alu_seq #(.W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));

    typedef struct {
        string       name;
        bit          w16;
        logic [2:0]  s;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] out;
        logic [3:0]  f;     // {z,n,c,v}
        int          lat;
    } vec_t;

    vec_t vq[$];
    int n_chk = 0;
    int n_fail = 0;

    function automatic vec_t mk(string nm, bit w16, logic [2:0] s, logic [15:0] a, logic [15:0] b,
                                logic [15:0] o, logic [3:0] f, int lat);
        vec_t t;
        t.name = nm; t.w16 = w16; t.s = s; t.a = a; t.b = b; t.out = o; t.f = f; t.lat = lat;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp(input bit w16, output logic ov, output logic rdy,
                        output logic [15:0] o, output logic [3:0] f);
        if (w16) begin
            ov = b16.out_valid; rdy = b16.in_ready; o = b16.out;
            f = {b16.z, b16.n, b16.c, b16.v};
        end else begin
            ov = b8.out_valid; rdy = b8.in_ready; o = {8'h00, b8.out};
            f = {b8.z, b8.n, b8.c, b8.v};
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic ov, rdy;
        logic [15:0] o;
        logic [3:0] f;
        int lat;
        b8.a = v.a[7:0]; b8.b = v.b[7:0]; b8.s = v.s;
        b16.a = v.a; b16.b = v.b; b16.s = v.s;
        samp(v.w16, ov, rdy, o, f);
        chk({v.name, " ready"}, 32'(rdy), 32'd1);
        if (v.w16) b16.in_valid = 1'b1; else b8.in_valid = 1'b1;
        tick();
        b8.in_valid = 1'b0; b16.in_valid = 1'b0;
        // scramble operands after accept; the DUT must use the captured copy
        b8.a = ~b8.a; b8.b = ~b8.b; b8.s = ~b8.s;
        b16.a = ~b16.a; b16.b = ~b16.b; b16.s = ~b16.s;
        lat = 1;
        samp(v.w16, ov, rdy, o, f);
        while (!ov && lat < 40) begin
            tick();
            lat++;
            samp(v.w16, ov, rdy, o, f);
        end
        chk({v.name, " latency"}, 32'(lat), 32'(v.lat));
        chk({v.name, " out"}, 32'(o), 32'(v.out));
        chk({v.name, " flags"}, 32'(f), 32'(v.f));
        tick();
        samp(v.w16, ov, rdy, o, f);
        chk({v.name, " hold"}, {15'd0, ov, o}, {15'd0, 1'b1, v.out});
        if (v.w16) b16.out_ready = 1'b1; else b8.out_ready = 1'b1;
        tick();
        b8.out_ready = 1'b0; b16.out_ready = 1'b0;
        samp(v.w16, ov, rdy, o, f);
        chk({v.name, " release"}, {14'd0, ov, rdy, o}, {14'd0, 1'b0, 1'b1, v.out});
    endtask

    initial begin
        logic ov, rdy;
        logic [15:0] o;
        logic [3:0] f;
        bit seen;

        b8.in_valid = 1'b1; b8.a = 8'h12; b8.b = 8'h34; b8.s = ADD; b8.out_ready = 1'b0;
        b16.in_valid = 1'b1; b16.a = 16'h1234; b16.b = 16'h0001; b16.s = ADD; b16.out_ready = 1'b0;

`ifdef ALU_SEQ_SAT_EN
        vq.push_back(mk("add_ovf8",  0, ADD,  16'h7F,   16'h01,   16'h7F,   4'b0001, 1));
        vq.push_back(mk("sub_ovf8",  0, SUB,  16'h80,   16'h01,   16'h80,   4'b0101, 1));
        vq.push_back(mk("add_negov", 0, ADD,  16'h80,   16'h80,   16'h80,   4'b0111, 1));
        vq.push_back(mk("add_ovf16", 1, ADD,  16'h7FFF, 16'h0001, 16'h7FFF, 4'b0001, 1));
`else
        vq.push_back(mk("add_ovf8",  0, ADD,  16'h7F,   16'h01,   16'h80,   4'b0101, 1));
        vq.push_back(mk("sub_ovf8",  0, SUB,  16'h80,   16'h01,   16'h7F,   4'b0001, 1));
        vq.push_back(mk("add_negov", 0, ADD,  16'h80,   16'h80,   16'h00,   4'b1011, 1));
        vq.push_back(mk("add_ovf16", 1, ADD,  16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 1));
`endif
        vq.push_back(mk("sub_borrow", 0, SUB,  16'h00,   16'h01,   16'hFF,   4'b0110, 1));
        vq.push_back(mk("sub_zero",   0, SUB,  16'h05,   16'h05,   16'h00,   4'b1000, 1));
        vq.push_back(mk("shl3",       0, SHL,  16'h81,   16'h03,   16'h08,   4'b0000, 4));
        vq.push_back(mk("shr1",       0, SHR,  16'h05,   16'h01,   16'h02,   4'b0010, 2));
        vq.push_back(mk("shl0",       0, SHL,  16'h5A,   16'h00,   16'h5A,   4'b0000, 1));
        vq.push_back(mk("and",        0, AND_, 16'hF0,   16'h3C,   16'h30,   4'b0000, 1));
        vq.push_back(mk("or",         0, OR_,  16'h0F,   16'hF0,   16'hFF,   4'b0100, 1));
        vq.push_back(mk("xor",        0, XOR_, 16'hAA,   16'hAA,   16'h00,   4'b1000, 1));
        vq.push_back(mk("not",        0, NOT_, 16'h0F,   16'h33,   16'hF0,   4'b0100, 1));
        vq.push_back(mk("add_carry",  0, ADD,  16'hFF,   16'h01,   16'h00,   4'b1010, 1));
        vq.push_back(mk("shr7",       0, SHR,  16'h80,   16'h07,   16'h01,   4'b0000, 8));
        vq.push_back(mk("shl1_c",     0, SHL,  16'h80,   16'h01,   16'h00,   4'b1010, 2));
        vq.push_back(mk("sub16",      1, SUB,  16'h0000, 16'h0001, 16'hFFFF, 4'b0110, 1));
        vq.push_back(mk("shl16",      1, SHL,  16'h8001, 16'h0003, 16'h0008, 4'b0000, 4));
        vq.push_back(mk("shr16",      1, SHR,  16'h0005, 16'h0001, 16'h0002, 4'b0010, 2));

        // reset state, with in_valid held high during reset
        tick(); tick();
        samp(0, ov, rdy, o, f);
        chk("reset8", {12'd0, ov, rdy, o, f}, {12'd0, 1'b0, 1'b1, 16'h0, 4'h0});
        samp(1, ov, rdy, o, f);
        chk("reset16", {12'd0, ov, rdy, o, f}, {12'd0, 1'b0, 1'b1, 16'h0, 4'h0});
        b8.in_valid = 1'b0; b16.in_valid = 1'b0;
        rst_n = 1'b1;

        foreach (vq[i]) run_vec(vq[i]);

        // backpressure: result held, new requests ignored
        b8.a = 8'hF0; b8.b = 8'h3C; b8.s = AND_; b8.in_valid = 1'b1;
        tick();
        b8.a = 8'h0F; b8.b = 8'h01; b8.s = OR_;
        for (int i = 0; i < 3; i++) begin
            samp(0, ov, rdy, o, f);
            chk("bp_hold", {13'd0, ov, rdy, o, f}, {13'd0, 1'b1, 1'b0, 16'h30, 4'b0000});
            tick();
        end
        b8.in_valid = 1'b0; b8.out_ready = 1'b1;
        tick();
        b8.out_ready = 1'b0;
        samp(0, ov, rdy, o, f);
        chk("bp_release", {13'd0, ov, rdy, o}, {13'd0, 1'b0, 1'b1, 16'h30});
        tick();
        samp(0, ov, rdy, o, f);
        chk("bp_no_queue", {30'd0, ov, rdy}, {30'd0, 1'b0, 1'b1});

        // reset in the middle of a long shift
        b8.a = 8'h80; b8.b = 8'h07; b8.s = SHR; b8.in_valid = 1'b1;
        tick();
        b8.in_valid = 1'b0;
        tick(); tick(); tick();
        samp(0, ov, rdy, o, f);
        chk("mid_shift_busy", {31'd0, rdy}, 32'd0);
        rst_n = 1'b0;
        #1;
        samp(0, ov, rdy, o, f);
        chk("mid_reset", {12'd0, ov, rdy, o, f}, {12'd0, 1'b0, 1'b1, 16'h0, 4'h0});
        b8.in_valid = 1'b1;
        tick(); tick();
        samp(0, ov, rdy, o, f);
        chk("in_reset_ignore", {30'd0, ov, rdy}, {30'd0, 1'b0, 1'b1});
        b8.in_valid = 1'b0;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (b8.out_valid) seen = 1'b1;
        end
        chk("no_valid_after_reset", 32'(seen), 32'd0);

        run_vec(mk("recover_and", 0, AND_, 16'h3C, 16'h0F, 16'h0C, 4'b0000, 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
